// File: rtl/inst_fetch.sv
// Instruction fetch stage: in-order request/grant fetch under a credit limit,
// prefetch FIFO toward the decoder, and branch redirect with stale-response discard.
module inst_fetch #(
  parameter logic [31:0] cResetPc   = 32'h0000_0000,
  parameter int          cFifoDepth = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iBranchTaken,
  input  logic [31:0] iBranchAddr,
  input  logic        iStall,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemGnt,
  input  logic        iMemValid,
  input  logic [31:0] iMemData,
  output logic        oInstDv,
  output logic [31:0] oInst,
  output logic [31:0] oPc
);

  localparam int CNT_W = $clog2(cFifoDepth + 1);
  localparam int PTR_W = $clog2(cFifoDepth);
  localparam logic [CNT_W+1:0] DEPTH_C = (CNT_W+2)'(cFifoDepth);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      inst_buf_q [0:cFifoDepth-1];
  logic [31:0]      inst_buf_d [0:cFifoDepth-1];
  logic [31:0]      pc_buf_q   [0:cFifoDepth-1];
  logic [31:0]      pc_buf_d   [0:cFifoDepth-1];

  logic [CNT_W+1:0] in_use;
  logic [31:0]      target;
  logic             fifo_empty;
  logic             gnt;
  logic             push;
  logic             pop;

  // Every buffered, in-flight or stale word holds one credit, so a push never finds the FIFO full
  assign in_use     = {2'b00, fifo_cnt_q} + {2'b00, outstanding_q} + {2'b00, discard_q};
  assign oMemReq    = ~iRst & (in_use < DEPTH_C);
  assign oMemAddr   = fetch_pc_q;
  assign gnt        = oMemReq & iMemGnt;
  assign target     = iBranchAddr & 32'hFFFF_FFFC;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = iMemValid & (discard_q == '0);
  assign pop        = oInstDv & ~iStall;

  assign oInstDv = ~fifo_empty;
  assign oInst   = fifo_empty ? 32'h0 : inst_buf_q[rd_ptr_q];
  assign oPc     = fifo_empty ? 32'h0 : pc_buf_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inst_buf_d    = inst_buf_q;
    pc_buf_d      = pc_buf_q;

    if (iBranchTaken) begin
      // Everything in flight, plus this cycle's grant, becomes stale; this cycle's response is dropped
      fetch_pc_d    = target;
      resp_pc_d     = target;
      fifo_cnt_d    = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q + CNT_W'(gnt) - CNT_W'(iMemValid);
    end else begin
      if (gnt) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        inst_buf_d[wr_ptr_q] = iMemData;
        pc_buf_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        resp_pc_d            = resp_pc_q + 32'd4;
      end
      if (iMemValid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(push);
      fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      fetch_pc_q    <= cResetPc;
      resp_pc_q     <= cResetPc;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < cFifoDepth; i++) begin
        inst_buf_q[i] <= 32'h0;
        pc_buf_q[i]   <= 32'h0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inst_buf_q    <= inst_buf_d;
      pc_buf_q      <= pc_buf_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC and issues word requests to instruction memory over a request/grant interface, in order and with any latency.
- Buffers returned words in a small prefetch FIFO and presents them, with their PC, to the decoder under a stall handshake.
- Handles branch redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
cResetPc, 32'h0000_0000, PC loaded on reset
cFifoDepth, 4, prefetch FIFO entries (power of two, >=2); also the cap on total in-flight requests

Ports:
iClk  in  1  clock, all state on rising edge
iRst  in  1  synchronous active-high reset
iBranchTaken  in  1  redirect strobe from execute
iBranchAddr  in  32  redirect target; bits [1:0] ignored and forced to 0
iStall  in  1  decoder cannot accept this cycle
oMemReq  in/out: out  1  fetch request valid
oMemAddr  out  32  word-aligned fetch address (= fetch PC)
iMemGnt  in  1  memory accepts request this cycle
iMemValid  in  1  read data valid (in order, >=1 cycle after grant)
iMemData  in  32  read data
oInstDv  out  1  oInst/oPc valid
oInst  out  32  instruction word to decoder
oPc  out  32  address of oInst

Behaviour:
- Reset (iRst=1 at an edge):
  - fetchPc=cResetPc; FIFO empty; outstanding=0; discard=0.
  - oMemReq=0, oInstDv=0, oInst=0, oPc=0.
  - The memory is reset with the same iRst, so no pre-reset response arrives afterwards.
- Counters are clog2(cFifoDepth+1) bits wide:
  - fifoCnt: entries held in the FIFO.
  - outstanding: live requests granted, response not yet received.
  - discard: stale requests whose responses must be dropped.
- Issue:
  - oMemReq=1 when not in reset and fifoCnt+outstanding+discard < cFifoDepth; driven from registered state only, no combinational path from iBranchTaken.
  - oMemAddr=fetchPc.
  - Grant (oMemReq&iMemGnt) with no redirect: fetchPc+=4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); outstanding+=1.
  - oMemReq/oMemAddr stay stable until granted.
- Response (iMemValid, no redirect):
  - If discard>0: discard-=1, data dropped.
  - Else: push {iMemData, respPc} into the FIFO, respPc+=4, outstanding-=1.
  - The credit rule guarantees the FIFO is never full on a push.
  - respPc tracks the PC of the next live response. It is loaded with cResetPc on reset and with the target on redirect.
- Output:
  - oInstDv = FIFO not empty; oInst/oPc = FIFO head.
  - Pop when oInstDv & !iStall.
  - Push and pop in the same cycle are allowed: fifoCnt unchanged.
  - Push into an empty FIFO is visible on oInstDv the next cycle (memory-to-decoder latency 1 cycle after iMemValid).
  - While iStall=1, oInst/oPc/oInstDv hold.
- Redirect (iBranchTaken=1), overriding all of the above that cycle:
  - fetchPc and respPc = {iBranchAddr[31:2],2'b00}; FIFO flushed (fifoCnt=0, no pop counted).
  - discard_next = discard + outstanding + (oMemReq&iMemGnt) - iMemValid; outstanding_next=0.
  - A grant in the redirect cycle is for the old PC and counts as stale.
  - A response in the redirect cycle is dropped.
  - oInstDv=0 the following cycle.
  - The first request to the target issues the cycle after the redirect, if credits allow.
- Back-to-back redirects: each one reapplies the rule; only the last target is fetched.
- Reset during a redirect or stall: reset wins.
- Throughput: with a 1-cycle memory, always-granted, and no stall, one instruction per cycle after a 2-cycle startup.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, iStall=0:
  - oMemAddr = 0,4,8,C on successive cycles.
  - oInstDv first high 2 cycles after the first grant, with oPc=0, 4, 8 consecutively.
  - oInst matches memory words.
- Hold iStall=1 for 10 cycles with gnt=1:
  - Exactly 4 requests granted, then oMemReq=0.
  - oInst/oPc frozen.
  - Release: 4 buffered words drain in order with no gaps, and fetch resumes.
- Memory latency 3, two requests outstanding, iBranchTaken with iBranchAddr=32'h103 in the same cycle as a grant:
  - discard=3; the next 3 iMemValid words never appear on oInst.
  - The first valid output has oPc=32'h100.
- Redirect in the same cycle as a pop and an iMemValid:
  - FIFO empty and oInstDv=0 next cycle.
  - Next oPc equals the target.
- fetchPc=32'hFFFF_FFFC: the next request address is 0; oPc sequence FFFF_FFFC -> 0000_0000.
- Assert iRst mid-stream with 3 FIFO entries and 2 outstanding:
  - All outputs 0 next cycle.
  - After release, fetch restarts at cResetPc with counters 0.
